// File: rtl/wb_slave_mux.sv
// wb_slave_mux: Wishbone fan-out from the management-SoC slave port to
// NUM_SLV user slaves. Each classic single cycle is decoded by address
// region and forwarded to one slave. Misses and slave timeouts complete
// with ERR_DATA and are recorded in a sticky flag and a saturating counter.
//
// Ports:
//   wb_clk, wb_rst        clock, asynchronous active-high reset
//   wbs_*                 upstream Wishbone slave (adr/wdata/sel/cyc/stb/we in,
//                         ack/rdata out)
//   m_cyc, m_stb          one-hot per-slave strobes
//   m_we/m_adr/m_wdata/m_sel  registered request fields shared by all slaves
//   m_ack, m_rdata        per-slave ack and read data (slave i on [32i+:32])
//   err_clr               pulse clearing err_flag and err_cnt
//   err_flag, err_cnt     sticky error flag and saturating error count
module wb_slave_mux #(
  parameter int unsigned NUM_SLV     = 4,
  parameter logic [31:0] BASE_ADDR   = 32'h3000_0000,
  parameter int unsigned REGION_BITS = 12,
  parameter int unsigned TIMEOUT     = 255,
  parameter logic [31:0] ERR_DATA    = 32'hDEAD_BEEF
) (
  input  logic                      wb_clk,
  input  logic                      wb_rst,
  input  logic [31:0]               wbs_adr,
  input  logic [31:0]               wbs_wdata,
  input  logic [3:0]                wbs_sel,
  input  logic                      wbs_cyc,
  input  logic                      wbs_stb,
  input  logic                      wbs_we,
  output logic                      wbs_ack,
  output logic [31:0]               wbs_rdata,
  output logic [NUM_SLV-1:0]        m_cyc,
  output logic [NUM_SLV-1:0]        m_stb,
  output logic                      m_we,
  output logic [REGION_BITS-1:0]    m_adr,
  output logic [31:0]               m_wdata,
  output logic [3:0]                m_sel,
  input  logic [NUM_SLV-1:0]        m_ack,
  input  logic [32*NUM_SLV-1:0]     m_rdata,
  input  logic                      err_clr,
  output logic                      err_flag,
  output logic [7:0]                err_cnt
);

  localparam int unsigned IDX_W   = (NUM_SLV > 1) ? $clog2(NUM_SLV) : 1;
  localparam int unsigned HI_LSB  = REGION_BITS + IDX_W;
  localparam int unsigned TMR_W   = 16;
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCESS = 2'd1,
    S_RESP   = 2'd2
  } state_t;

  state_t               state_q, state_nxt;
  logic [IDX_W-1:0]     idx_q, idx_nxt;
  logic [TMR_W-1:0]     tmr_q, tmr_nxt;

  logic                 wbs_ack_nxt;
  logic [31:0]          wbs_rdata_nxt;
  logic [NUM_SLV-1:0]   m_cyc_nxt, m_stb_nxt;
  logic                 m_we_nxt;
  logic [REGION_BITS-1:0] m_adr_nxt;
  logic [31:0]          m_wdata_nxt;
  logic [3:0]           m_sel_nxt;
  logic                 err_flag_nxt;
  logic [7:0]           err_cnt_nxt;

  // Address decode of the incoming request
  logic [IDX_W-1:0]     req_idx;
  logic                 req_hit;
  logic [31:0]          slv_rdata;
  logic                 slv_ack;

  assign req_idx = wbs_adr[REGION_BITS +: IDX_W];
  assign req_hit = (wbs_adr[31:HI_LSB] == BASE_ADDR[31:HI_LSB]) &&
                   (32'(req_idx) < 32'(NUM_SLV));

  // Only the selected slave's ack and data are looked at
  assign slv_ack   = m_ack[idx_q];
  assign slv_rdata = m_rdata[32*32'(idx_q) +: 32];

  // Next-state and next-output logic
  always_comb begin
    logic err_event;

    state_nxt     = state_q;
    idx_nxt       = idx_q;
    tmr_nxt       = tmr_q;
    wbs_ack_nxt   = 1'b0;
    wbs_rdata_nxt = '0;
    m_cyc_nxt     = m_cyc;
    m_stb_nxt     = m_stb;
    m_we_nxt      = m_we;
    m_adr_nxt     = m_adr;
    m_wdata_nxt   = m_wdata;
    m_sel_nxt     = m_sel;
    err_flag_nxt  = err_flag;
    err_cnt_nxt   = err_cnt;
    err_event     = 1'b0;

    if (err_clr) begin
      err_flag_nxt = 1'b0;
      err_cnt_nxt  = 8'd0;
    end

    case (state_q)
      S_IDLE: begin
        if (wbs_cyc && wbs_stb) begin
          m_adr_nxt   = wbs_adr[REGION_BITS-1:0];
          m_wdata_nxt = wbs_wdata;
          m_sel_nxt   = wbs_sel;
          m_we_nxt    = wbs_we;
          idx_nxt     = req_idx;
          if (req_hit) begin
            state_nxt = S_ACCESS;
            m_cyc_nxt = NUM_SLV'(1) << req_idx;
            m_stb_nxt = NUM_SLV'(1) << req_idx;
            tmr_nxt   = '0;
          end else begin
            state_nxt     = S_RESP;
            wbs_ack_nxt   = 1'b1;
            wbs_rdata_nxt = ERR_DATA;
            err_event     = 1'b1;
          end
        end
      end

      S_ACCESS: begin
        // Abort beats ack, ack beats timeout
        if (!wbs_cyc) begin
          state_nxt = S_IDLE;
          m_cyc_nxt = '0;
          m_stb_nxt = '0;
        end else if (slv_ack) begin
          state_nxt     = S_RESP;
          wbs_ack_nxt   = 1'b1;
          wbs_rdata_nxt = slv_rdata;
          m_cyc_nxt     = '0;
          m_stb_nxt     = '0;
        end else if (tmr_q == TMR_LAST) begin
          state_nxt     = S_RESP;
          wbs_ack_nxt   = 1'b1;
          wbs_rdata_nxt = ERR_DATA;
          m_cyc_nxt     = '0;
          m_stb_nxt     = '0;
          err_event     = 1'b1;
        end else begin
          tmr_nxt = tmr_q + TMR_W'(1);
        end
      end

      S_RESP: begin
        state_nxt = S_IDLE;
      end

      default: begin
        state_nxt = S_IDLE;
        m_cyc_nxt = '0;
        m_stb_nxt = '0;
      end
    endcase

    // An error event overrides a coincident clear: count restarts at 1
    if (err_event) begin
      err_flag_nxt = 1'b1;
      if (err_clr)
        err_cnt_nxt = 8'd1;
      else if (err_cnt != 8'hFF)
        err_cnt_nxt = err_cnt + 8'd1;
    end
  end

  // State and output registers
  always_ff @(posedge wb_clk or posedge wb_rst) begin
    if (wb_rst) begin
      state_q   <= S_IDLE;
      idx_q     <= '0;
      tmr_q     <= '0;
      wbs_ack   <= 1'b0;
      wbs_rdata <= '0;
      m_cyc     <= '0;
      m_stb     <= '0;
      m_we      <= 1'b0;
      m_adr     <= '0;
      m_wdata   <= '0;
      m_sel     <= '0;
      err_flag  <= 1'b0;
      err_cnt   <= '0;
    end else begin
      state_q   <= state_nxt;
      idx_q     <= idx_nxt;
      tmr_q     <= tmr_nxt;
      wbs_ack   <= wbs_ack_nxt;
      wbs_rdata <= wbs_rdata_nxt;
      m_cyc     <= m_cyc_nxt;
      m_stb     <= m_stb_nxt;
      m_we      <= m_we_nxt;
      m_adr     <= m_adr_nxt;
      m_wdata   <= m_wdata_nxt;
      m_sel     <= m_sel_nxt;
      err_flag  <= err_flag_nxt;
      err_cnt   <= err_cnt_nxt;
    end
  end

endmodule

// File: tb/tb_wb_slave_mux.sv
// Directed self-checking bench for wb_slave_mux (NUM_SLV=4, TIMEOUT=16).
// Inputs are driven and outputs sampled on the falling clock edge.
module tb_wb_slave_mux;

  localparam int unsigned NUM_SLV = 4;
  localparam int unsigned TMO     = 16;

  logic                   wb_clk;
  logic                   wb_rst;
  logic [31:0]            wbs_adr;
  logic [31:0]            wbs_wdata;
  logic [3:0]             wbs_sel;
  logic                   wbs_cyc;
  logic                   wbs_stb;
  logic                   wbs_we;
  logic                   wbs_ack;
  logic [31:0]            wbs_rdata;
  logic [NUM_SLV-1:0]     m_cyc;
  logic [NUM_SLV-1:0]     m_stb;
  logic                   m_we;
  logic [11:0]            m_adr;
  logic [31:0]            m_wdata;
  logic [3:0]             m_sel;
  logic [NUM_SLV-1:0]     m_ack;
  logic [32*NUM_SLV-1:0]  m_rdata;
  logic                   err_clr;
  logic                   err_flag;
  logic [7:0]             err_cnt;

  // Slave model: registered-style acks from the bench plus optional zero-wait slaves
  logic [NUM_SLV-1:0]     ack_drv;
  logic [NUM_SLV-1:0]     zw_mask;
  assign m_ack = ack_drv | (m_stb & zw_mask);

  int checks = 0;
  int errors = 0;

  wb_slave_mux #(
    .NUM_SLV    (NUM_SLV),
    .BASE_ADDR  (32'h3000_0000),
    .REGION_BITS(12),
    .TIMEOUT    (TMO),
    .ERR_DATA   (32'hDEAD_BEEF)
  ) dut (
    .wb_clk   (wb_clk),
    .wb_rst   (wb_rst),
    .wbs_adr  (wbs_adr),
    .wbs_wdata(wbs_wdata),
    .wbs_sel  (wbs_sel),
    .wbs_cyc  (wbs_cyc),
    .wbs_stb  (wbs_stb),
    .wbs_we   (wbs_we),
    .wbs_ack  (wbs_ack),
    .wbs_rdata(wbs_rdata),
    .m_cyc    (m_cyc),
    .m_stb    (m_stb),
    .m_we     (m_we),
    .m_adr    (m_adr),
    .m_wdata  (m_wdata),
    .m_sel    (m_sel),
    .m_ack    (m_ack),
    .m_rdata  (m_rdata),
    .err_clr  (err_clr),
    .err_flag (err_flag),
    .err_cnt  (err_cnt)
  );

  initial wb_clk = 1'b0;
  always #5 wb_clk = ~wb_clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge wb_clk);
  endtask

  task automatic req(input logic [31:0] adr, input logic we, input logic [31:0] wd,
                     input logic [3:0] sel);
    wbs_adr   = adr;
    wbs_we    = we;
    wbs_wdata = wd;
    wbs_sel   = sel;
    wbs_cyc   = 1'b1;
    wbs_stb   = 1'b1;
  endtask

  task automatic drop();
    wbs_cyc = 1'b0;
    wbs_stb = 1'b0;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_ack"},   32'(wbs_ack),  32'h0);
    check({tag, "_rdata"}, wbs_rdata,     32'h0);
    check({tag, "_cyc"},   32'(m_cyc),    32'h0);
    check({tag, "_stb"},   32'(m_stb),    32'h0);
    check({tag, "_we"},    32'(m_we),     32'h0);
    check({tag, "_adr"},   32'(m_adr),    32'h0);
    check({tag, "_wdata"}, m_wdata,       32'h0);
    check({tag, "_sel"},   32'(m_sel),    32'h0);
    check({tag, "_flag"},  32'(err_flag), 32'h0);
    check({tag, "_cnt"},   32'(err_cnt),  32'h0);
  endtask

  initial begin
    logic seen_ack;

    wb_rst  = 1'b1;
    wbs_adr = '0; wbs_wdata = '0; wbs_sel = '0; wbs_we = 1'b0;
    wbs_cyc = 1'b0; wbs_stb = 1'b0;
    ack_drv = '0; zw_mask = '0; m_rdata = '0; err_clr = 1'b0;

    // Reset state
    step(); step();
    check_all_zero("rst");
    wb_rst = 1'b0;
    step();

    // Read hit, slave 2 acks after 3 cycles
    req(32'h3000_2008, 1'b0, 32'h0, 4'hF);
    step();                                    // E0
    check("rd_stb", 32'(m_stb), 32'h4);
    check("rd_cyc", 32'(m_cyc), 32'h4);
    check("rd_adr", 32'(m_adr), 32'h008);
    check("rd_ack_e0", 32'(wbs_ack), 32'h0);
    step();                                    // E1
    step();                                    // E2
    check("rd_ack_e2", 32'(wbs_ack), 32'h0);
    ack_drv[2] = 1'b1;
    m_rdata[64 +: 32] = 32'h1234_5678;
    step();                                    // E3 samples ack
    check("rd_ack", 32'(wbs_ack), 32'h1);
    check("rd_data", wbs_rdata, 32'h1234_5678);
    check("rd_stb_off", 32'(m_stb), 32'h0);
    check("rd_errcnt", 32'(err_cnt), 32'h0);
    ack_drv = '0;
    drop();
    step();
    check("rd_ack_single", 32'(wbs_ack), 32'h0);

    // Write hit, slave 3 zero-wait
    zw_mask = 4'b1000;
    m_rdata[96 +: 32] = 32'h0BAD_F00D;
    req(32'h3000_3FFC, 1'b1, 32'hA5A5_A5A5, 4'b0011);
    step();                                    // E0
    check("wr_stb", 32'(m_stb), 32'h8);
    check("wr_adr", 32'(m_adr), 32'hFFC);
    check("wr_wdata", m_wdata, 32'hA5A5_A5A5);
    check("wr_sel", 32'(m_sel), 32'h3);
    check("wr_we", 32'(m_we), 32'h1);
    check("wr_ack_e0", 32'(wbs_ack), 32'h0);
    step();                                    // E1
    check("wr_ack", 32'(wbs_ack), 32'h1);
    check("wr_data", wbs_rdata, 32'h0BAD_F00D);
    check("wr_stb_off", 32'(m_stb), 32'h0);
    drop();
    zw_mask = '0;
    step();
    check("wr_ack_single", 32'(wbs_ack), 32'h0);

    // Miss
    req(32'h3100_0000, 1'b0, 32'h0, 4'hF);
    step();                                    // E0
    check("miss_ack", 32'(wbs_ack), 32'h1);
    check("miss_stb", 32'(m_stb), 32'h0);
    check("miss_data", wbs_rdata, 32'hDEAD_BEEF);
    check("miss_flag", 32'(err_flag), 32'h1);
    check("miss_cnt", 32'(err_cnt), 32'h1);
    drop();
    step();
    check("miss_ack_single", 32'(wbs_ack), 32'h0);

    // Timeout on slave 1
    req(32'h3000_1000, 1'b0, 32'h0, 4'hF);
    step();                                    // E0
    check("tmo_stb", 32'(m_stb), 32'h2);
    seen_ack = 1'b0;
    for (int i = 1; i < TMO; i++) begin
      step();
      if (wbs_ack) seen_ack = 1'b1;
    end
    check("tmo_early_ack", 32'(seen_ack), 32'h0);
    step();                                    // E16
    check("tmo_ack", 32'(wbs_ack), 32'h1);
    check("tmo_data", wbs_rdata, 32'hDEAD_BEEF);
    check("tmo_stb_off", 32'(m_stb), 32'h0);
    check("tmo_cnt", 32'(err_cnt), 32'h2);
    drop();
    step();

    // Ack on the final timeout edge wins
    req(32'h3000_1004, 1'b0, 32'h0, 4'hF);
    step();                                    // E0
    for (int i = 1; i < TMO; i++) step();
    ack_drv[1] = 1'b1;
    m_rdata[32 +: 32] = 32'hCAFE_0001;
    step();                                    // E16
    check("edge_ack", 32'(wbs_ack), 32'h1);
    check("edge_data", wbs_rdata, 32'hCAFE_0001);
    check("edge_cnt", 32'(err_cnt), 32'h2);
    ack_drv = '0;
    drop();
    step();

    // Clear, then saturate with 260 misses
    err_clr = 1'b1;
    step();
    err_clr = 1'b0;
    check("clr_cnt", 32'(err_cnt), 32'h0);
    check("clr_flag", 32'(err_flag), 32'h0);
    for (int i = 0; i < 260; i++) begin
      req(32'h3100_0000, 1'b0, 32'h0, 4'hF);
      step();
      drop();
      step();
    end
    check("sat_cnt", 32'(err_cnt), 32'hFF);
    check("sat_flag", 32'(err_flag), 32'h1);
    err_clr = 1'b1;
    step();
    err_clr = 1'b0;
    check("clr2_cnt", 32'(err_cnt), 32'h0);

    // Clear coincident with a miss
    req(32'h3100_0000, 1'b0, 32'h0, 4'hF);
    err_clr = 1'b1;
    step();
    err_clr = 1'b0;
    check("coin_ack", 32'(wbs_ack), 32'h1);
    check("coin_cnt", 32'(err_cnt), 32'h1);
    check("coin_flag", 32'(err_flag), 32'h1);
    drop();
    step();

    // Abort mid-ACCESS
    req(32'h3000_0000, 1'b0, 32'h0, 4'hF);
    step();                                    // E0
    check("abt_stb", 32'(m_stb), 32'h1);
    step();                                    // E1
    drop();
    step();                                    // E2 sees cyc low
    check("abt_stb_off", 32'(m_stb), 32'h0);
    check("abt_cyc_off", 32'(m_cyc), 32'h0);
    check("abt_ack", 32'(wbs_ack), 32'h0);
    step();
    check("abt_ack_late", 32'(wbs_ack), 32'h0);
    check("abt_cnt", 32'(err_cnt), 32'h1);

    // Reset mid-ACCESS, then a normal read
    req(32'h3000_2010, 1'b1, 32'h1111_2222, 4'hC);
    step();                                    // E0
    check("rstm_stb", 32'(m_stb), 32'h4);
    wb_rst = 1'b1;
    #1;
    check_all_zero("rstm");
    drop();
    step();
    wb_rst = 1'b0;
    step();
    req(32'h3000_2004, 1'b0, 32'h0, 4'hF);
    step();                                    // E0
    check("post_stb", 32'(m_stb), 32'h4);
    check("post_adr", 32'(m_adr), 32'h004);
    ack_drv[2] = 1'b1;
    m_rdata[64 +: 32] = 32'h7777_0000;
    step();                                    // E1
    check("post_ack", 32'(wbs_ack), 32'h1);
    check("post_data", wbs_rdata, 32'h7777_0000);
    check("post_cnt", 32'(err_cnt), 32'h0);
    ack_drv = '0;
    drop();
    step();
    check("post_ack_single", 32'(wbs_ack), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/wb_slave_mux.md
# wb_slave_mux

Parametrised Wishbone fan-out stage between the Caravel management-SoC Wishbone slave port and `NUM_SLV` user-project slaves inside FSIC. It decodes each single classic-cycle request by address region and forwards it to one slave. It returns that slave's ack and read data. Accesses that miss every region, or that a slave fails to answer within `TIMEOUT` cycles, are terminated with an error response, a sticky error flag and a saturating error count, so the management core never hangs.

## Interface
Parameters:
- `NUM_SLV`, 4: number of downstream slaves, 1..16. `IDX_W = max(1, clog2(NUM_SLV))`.
- `BASE_ADDR`, 32'h3000_0000: window base.
- `REGION_BITS`, 12: log2 of region size (4 KB per slave).
- `TIMEOUT`, 255: maximum cycles spent in ACCESS, 2..65535.
- `ERR_DATA`, 32'hDEAD_BEEF: read data returned on any error.

Ports:
- `wb_clk`  in  1  single clock.
- `wb_rst`  in  1  asynchronous, active-high reset.
- `wbs_adr`  in  32  request address.
- `wbs_wdata`  in  32  write data.
- `wbs_sel`  in  4  byte lanes.
- `wbs_cyc`, `wbs_stb`, `wbs_we`  in  1 each  Wishbone classic controls.
- `wbs_ack`  out  1  one-cycle completion pulse.
- `wbs_rdata`  out  32  read data, valid while `wbs_ack` is high.
- `m_cyc`, `m_stb`  out  NUM_SLV  one-hot per-slave strobes.
- `m_we`  out  1  registered copy of `wbs_we`.
- `m_adr`  out  REGION_BITS  registered `wbs_adr[REGION_BITS-1:0]`.
- `m_wdata`  out  32  registered write data.
- `m_sel`  out  4  registered byte lanes.
- `m_ack`  in  NUM_SLV  per-slave ack.
- `m_rdata`  in  32*NUM_SLV  slave i read data on bits [32i+31:32i].
- `err_clr`  in  1  one-cycle pulse; clears `err_flag` and `err_cnt`.
- `err_flag`  out  1  sticky error indication, usable as a user_irq source.
- `err_cnt`  out  8  saturating error counter.

## Operation
- Decode:
  - `idx = wbs_adr[REGION_BITS +: IDX_W]`.
  - hit = (`wbs_adr[31:REGION_BITS+IDX_W]` == `BASE_ADDR[31:REGION_BITS+IDX_W]`) && (`idx < NUM_SLV`).
- FSM states are IDLE, ACCESS and RESP.
- IDLE:
  - On an edge where `wbs_cyc & wbs_stb` is high, register adr, wdata, sel, we and idx.
  - On a hit, go to ACCESS; `m_cyc[idx]` and `m_stb[idx]` go high and the timeout counter loads 0.
  - On a miss, go to RESP with error = 1.
- ACCESS:
  - `m_ack[idx]` sampled high: capture `m_rdata[idx]` and go to RESP with error = 0.
  - Otherwise, if counter == TIMEOUT-1: go to RESP with error = 1.
  - Otherwise the counter increments.
  - `m_ack` bits of non-selected slaves are ignored.
  - `wbs_cyc` sampled low (abort): go to IDLE, drop the strobes, no `wbs_ack`, no error. Abort has priority over both ack and timeout.
- RESP:
  - `wbs_ack` = 1 for exactly one cycle.
  - `wbs_rdata` = captured slave data, or `ERR_DATA` on error (both reads and writes).
  - Then go to IDLE unconditionally.
- Leaving ACCESS deasserts all `m_cyc`/`m_stb` on the same edge.
- Error event (miss or timeout) on entry to RESP:
  - `err_flag` is set.
  - `err_cnt` increments, saturating at 255.
- `err_clr` in the same cycle as an error event: the event wins. `err_flag` = 1 and `err_cnt` = 1.
- Only one transaction is outstanding. Requests arriving outside IDLE are not sampled.

## Timing
- Reset (asynchronous, immediate) returns the FSM to IDLE and drives every output to 0: `wbs_ack`, `wbs_rdata`, `m_cyc`, `m_stb`, `m_we`, `m_adr`, `m_wdata`, `m_sel`, `err_flag`, `err_cnt`.
  - Reset mid-ACCESS drops the strobes without a response.
- Request sampled at edge E0:
  - Hit: `m_stb` is high from E0.
  - Miss: `wbs_ack` is high during E0..E1.
- Slave ack sampled at edge Ek: `wbs_ack` is high during Ek..Ek+1, with `m_stb` already low.
  - A zero-wait slave (combinational ack) gives `wbs_ack` 2 cycles after the request.
- Timeout with no ack: `wbs_ack` rises TIMEOUT cycles after `m_stb` rose.
  - Ack and timeout sampled on the same edge: ack wins, no error.
- The master must drop `stb` the cycle after `wbs_ack`. The FSM is back in IDLE on that edge, so back-to-back requests are spaced at least 1 idle cycle apart.
- All outputs are registered. There is no combinational path from `m_ack` to `wbs_ack`.

## Test plan
- Use defaults, with TIMEOUT = 16 where a timeout is needed.
- Read hit: read 0x3000_2008; slave 2 acks after 3 cycles with 0x1234_5678 -> `m_stb` = 4'b0100, `m_adr` = 12'h008, `wbs_rdata` = 0x1234_5678, single `wbs_ack`, `err_cnt` = 0.
- Write hit, zero-wait: write 0x3000_3FFC, data 0xA5A5_A5A5, sel 4'b0011; slave 3 acks combinationally -> `m_wdata`/`m_sel` match, `wbs_ack` 2 cycles after the request, other strobes stay 0.
- Miss: read 0x3100_0000 -> no `m_stb`, `wbs_ack` one cycle after the request, `wbs_rdata` = 0xDEAD_BEEF, `err_flag` = 1, `err_cnt` = 1.
- Timeout: slave 1 never acks, TIMEOUT = 16 -> `wbs_ack` 16 cycles after `m_stb`, 0xDEAD_BEEF returned. Ack arriving exactly on the 16th edge -> normal data, no error.
- Saturation and clear: 260 misses -> `err_cnt` = 255. `err_clr` pulse -> 0. `err_clr` coincident with a miss -> `err_cnt` = 1, `err_flag` = 1.
- Abort and reset: drop `wbs_cyc` mid-ACCESS -> strobes low next edge, no ack. Assert `wb_rst` mid-ACCESS -> all outputs 0 immediately, then the next read completes normally.
